// File: rtl/setup_sequencer.sv
// Power-up sequencer: one-cycle start pulse per channel, each fired a configurable
// number of counting edges after the previous one, with hold, rearm and repeat.
module setup_sequencer #(
  parameter int unsigned                  CHANNELS = 4,
  parameter int unsigned                  CNT_W    = 32,
  parameter logic [CHANNELS*CNT_W-1:0]    DELAY    = {CHANNELS{CNT_W'(32'hFFFF)}},
  parameter bit                           REPEAT   = 1'b0,
  localparam int unsigned                 SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hold,
  input  logic                rearm,
  output logic [CHANNELS-1:0] setup_start,
  output logic [SW-1:0]       stage,
  output logic                busy,
  output logic                done
);

  typedef enum logic {StRun, StDone} state_e;

  localparam logic [SW-1:0] LastStage = SW'(CHANNELS - 1);

  state_e                state_q;
  logic [SW-1:0]         stage_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CHANNELS-1:0]   start_q;
  logic                  busy_q;
  logic                  done_q;

  function automatic logic [CNT_W-1:0] delay_of(input int unsigned k);
    return DELAY[k*CNT_W +: CNT_W];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || rearm) begin
      // rearm restarts exactly like reset release; issued pulses are left alone
      state_q <= StRun;
      stage_q <= '0;
      cnt_q   <= delay_of(0);
      start_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else if (state_q == StDone) begin
      start_q <= '0;
      done_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else if (hold) begin
      start_q <= '0;
      done_q  <= 1'b0;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_q   <= cnt_q - CNT_W'(1);
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // cnt of 0 or 1 fires, so a zero delay field acts as one
      start_q <= CHANNELS'(1) << stage_q;
      if (stage_q != LastStage) begin
        stage_q <= stage_q + 1'b1;
        cnt_q   <= delay_of(int'(stage_q) + 1);
        done_q  <= 1'b0;
      end else if (REPEAT) begin
        stage_q <= '0;
        cnt_q   <= delay_of(0);
        done_q  <= 1'b1;
      end else begin
        state_q <= StDone;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign setup_start = start_q;
  assign stage       = stage_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/setup_sequencer.md
# setup_sequencer

Parametrised power-up sequencer for the laser projector that replaces the single delayed setup pulse with an ordered train of one-cycle start pulses, one per downstream channel (e.g. DAC init, galvo init, laser enable, pinball game start). Each channel fires a configurable number of cycles after the previous one. The block adds a pause input, a rearm input and an optional free-running repeat mode. It sits beside the reset logic and drives the `*_start` inputs of the setup blocks.

## Interface
- `CHANNELS`, default 4: number of pulse outputs; ≥1.
- `CNT_W`, default 32: delay counter width.
- `DELAY`, default {CHANNELS{32'hFFFF}}: packed delays. Field k is `DELAY[k*CNT_W +: CNT_W]`. Field 0 is measured from reset release; field k is measured from the channel k-1 pulse.
- `REPEAT`, default 0: 0 = one-shot, 1 = restart at channel 0 after the last channel.
- `clk`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `hold`, input, 1: 1 freezes the countdown.
- `rearm`, input, 1: restarts the sequence from channel 0.
- `setup_start`, output, CHANNELS: one-hot, one-cycle start pulses; bit k belongs to channel k.
- `stage`, output, SW: index of the channel currently counting. SW = max(1, $clog2(CHANNELS)).
- `busy`, output, 1: sequence in progress.
- `done`, output, 1: one-shot mode is a level (all channels fired); repeat mode is a one-cycle pulse per pass.

## Operation
- State: `RUN` / `DONE` flag, stage register, down-counter `cnt` (CNT_W bits).
- Reset (reset_n=0 at an edge):
  - state=RUN, stage=0, cnt=DELAY[0].
  - setup_start=0, done=0, busy=1.
- Priority at each edge: reset, then rearm, then hold, then count.
- rearm=1 (any state, including mid-count or DONE):
  - stage=0, cnt=DELAY[0], setup_start=0, done=0, busy=1, state=RUN.
  - Pulses already issued are not revoked.
- hold=1 in RUN:
  - cnt and stage are frozen; setup_start=0.
  - A pulse issued on the previous edge still drops after one cycle.
- Count in RUN, hold=0:
  - cnt>1: cnt=cnt-1, setup_start=0.
  - cnt≤1: setup_start is one-hot at bit `stage`, then:
    - stage<CHANNELS-1: stage=stage+1, cnt=DELAY[stage+1].
    - Last stage, REPEAT=0: state=DONE, done=1, busy=0; stage holds CHANNELS-1.
    - Last stage, REPEAT=1: stage=0, cnt=DELAY[0], done=1 for this cycle only, busy stays 1.
- A DELAY field of 0 behaves as 1, so the pulse fires on the first counting edge.
- DONE: all outputs are static (setup_start=0, done=1, busy=0) until rearm or reset.
- Arithmetic: cnt never wraps. The decrement happens only when cnt>1.

## Timing
- Latency: the channel 0 pulse is high in the cycle after the D0-th rising edge at which reset_n=1 and hold=0. For delay fields 2 and above, rearm behaves like reset release.
- Channel k's pulse comes exactly max(DELAY[k],1) non-held edges after channel k-1's pulse edge.
- Each setup_start bit is high for exactly one cycle. Bits are never simultaneous, and no two consecutive cycles pulse the same bit unless CHANNELS=1 with delay ≤1 in repeat mode.
- done and busy change on the same edge that asserts the last pulse.
- Pulses are suppressed while reset_n=0, regardless of the other inputs.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic sequence.** CHANNELS=3, CNT_W=8, DELAY={4,3,5} (ch0=5, ch1=3, ch2=4), release reset at edge 0 → ch0 pulses after edge 5, ch1 after edge 8, ch2 after edge 12. done=1 and busy=0 from edge 12 and stay there; stage reads 0, 1, 2.
- **Hold.** Same config, hold=1 for edges 2–4 → ch0 slips to edge 8, ch1 to edge 11, ch2 to edge 15. A pulse issued before hold rises still lasts exactly one cycle.
- **Rearm.**
  - rearm at edge 7 (mid ch1 count) → no ch1 at 8; stage=0, done=0; ch0 re-pulses 5 edges after the rearm edge.
  - rearm in DONE → the full sequence repeats.
- **Zero delay and CHANNELS=1.**
  - DELAY field 0 → pulse on the first counting edge.
  - CHANNELS=1, SW=1 → a single pulse, then done.
- **Repeat mode.** REPEAT=1, DELAY={2,2,2} → pulses every 2 edges cycling ch0, ch1, ch2, ch0…. done pulses one cycle alongside each ch2 pulse; busy stays 1.
- **Reset mid-operation.** reset_n=0 for 1 cycle at edge 9 → all outputs cleared (busy=1); the sequence restarts, with ch0 pulsing 5 edges after release.
